atm_account_store: RTL and testbench
====================================

// Module: atm_account_store
// PURPOSE
//  Account-database responder for the ATM controller FSM (the initiator). Holds per-card
//  {valid,password} and {up_limit,credit} records, accepts one request at a time on a
//  valid/ready channel, validates it, performs atomic read-modify-write, returns status + balance.
//  Sits between the ATM controller and the card/account storage.
// PARAMETERS
//  CREDIT_VAL_SIZE 25  credit field width (unsigned)
//  UP_LIMIT_SIZE   15  per-transaction withdraw/transfer limit width
//  PASSWORD_SIZE   16  password width
//  PINCARD_SIZE     6  card index width
//  DEPTH           64  number of accounts (2**PINCARD_SIZE)
//  AMOUNT_SIZE     15  request amount width (= WITHDRAW/DEPOSITE/TRANSFER_SIZE)
// PORTS
//  clk          in   1   single clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  init_en      in   1   load one account record (bench/provisioning)
//  init_card    in   6   record index
//  init_valid   in   1   card valid bit to store
//  init_pass    in  16   password to store
//  init_limit   in  15   up_limit to store
//  init_credit  in  25   credit to store
//  req_valid    in   1   request valid
//  req_ready    out  1   request accepted when req_valid&&req_ready
//  req_op       in   2   0 LOOKUP, 1 DEPOSIT, 2 WITHDRAW, 3 TRANSFER
//  req_card     in   6   source card
//  req_dest     in   6   destination card (TRANSFER only)
//  req_pass     in  16   entered password
//  req_amount   in  15   amount (ignored for LOOKUP)
//  rsp_valid    out  1   response valid, held until rsp_ready
//  rsp_ready    in   1   response consumed when rsp_valid&&rsp_ready
//  rsp_status   out  3   0 OK,1 BAD_CARD,2 BAD_PASS,3 BAD_DEST,4 OVER_LIMIT,5 INSUFFICIENT,6 OVERFLOW
//  rsp_credit   out 25   source credit after the operation
// BEHAVIOUR
//  Reset: state IDLE; rsp_valid=0, rsp_status=0, rsp_credit=0; all 64 valid bits cleared.
//   Password/limit/credit arrays not reset. Reset mid-operation aborts with no memory write.
//  req_ready = (state==IDLE) && !init_en; request fields captured at accept.
//  init_en sampled only in IDLE; writes record next edge; ignored in any other state.
//  FSM: IDLE -> RD_SRC -> CHK_SRC -> {RESP | WR | RD_DST} ; RD_DST -> CHK_DST -> {RESP | WR};
//   WR -> RESP ; RESP -> IDLE on rsp_ready (same-cycle handshake allowed).
//  Latency (accept edge = T): LOOKUP/failure in CHK_SRC: rsp_valid at T+3;
//   DEPOSIT/WITHDRAW OK: T+4; TRANSFER fail in CHK_DST: T+5; TRANSFER OK: T+6.
//  RD_* registers the addressed record (1-cycle read); CHK_* evaluates in fixed priority:
//   CHK_SRC: !valid->BAD_CARD; pass mismatch->BAD_PASS; WITHDRAW/TRANSFER: amount>up_limit
//   ->OVER_LIMIT; amount>credit->INSUFFICIENT; DEPOSIT: credit+amount>2**25-1->OVERFLOW.
//   CHK_DST: dest==card or !dest.valid->BAD_DEST; dest.credit+amount overflow->OVERFLOW.
//  Arithmetic: AMOUNT zero-extended to 25 bits; sum computed at 26 bits, bit 25 = overflow.
//  Equalities are OK: amount==up_limit, amount==credit, sum==2**25-1 all pass.
//  WR: single cycle, writes new credit(s); TRANSFER writes src and dst on the same edge (atomic).
//  Any failure: no write, rsp_credit = stored source credit; BAD_CARD: rsp_credit=0.
//  Destination password not checked. up_limit never modified by requests.
//  New request never accepted while rsp_valid=1 (back-pressure holds response stable).
// TESTING
//  Init card 5 {1,0x1234,limit 500,credit 1000}; LOOKUP pass 0x1234 -> OK,1000 at T+3.
//  WITHDRAW card5 500 -> OK,500 at T+4; again 501 -> OVER_LIMIT,500; then 500,500 -> OK,0.
//  Card 5 wrong pass 0x1235 -> BAD_PASS; card 9 never inited -> BAD_CARD, credit 0.
//  DEPOSIT 1 to credit 2**25-1 -> OVERFLOW, unchanged; 0 to same -> OK.
//  TRANSFER 200 card5(1000)->card7(50) -> OK,800 at T+6; LOOKUP card7 -> 250; dest=5 -> BAD_DEST.
//  Hold rsp_ready=0 10 cycles -> rsp stable, req_ready=0; assert rst_n low in WR-1 -> no write.

Source files
------------

// File: rtl/atm_account_store.sv
// Account-record responder for the ATM controller: one request at a time,
// read record, validate, atomic read-modify-write of credit(s), respond.
module atm_account_store #(
    parameter int CREDIT_VAL_SIZE = 25,
    parameter int UP_LIMIT_SIZE   = 15,
    parameter int PASSWORD_SIZE   = 16,
    parameter int PINCARD_SIZE    = 6,
    parameter int DEPTH           = 64,
    parameter int AMOUNT_SIZE     = 15
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       init_en,
    input  logic [PINCARD_SIZE-1:0]    init_card,
    input  logic                       init_valid,
    input  logic [PASSWORD_SIZE-1:0]   init_pass,
    input  logic [UP_LIMIT_SIZE-1:0]   init_limit,
    input  logic [CREDIT_VAL_SIZE-1:0] init_credit,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [1:0]                 req_op,
    input  logic [PINCARD_SIZE-1:0]    req_card,
    input  logic [PINCARD_SIZE-1:0]    req_dest,
    input  logic [PASSWORD_SIZE-1:0]   req_pass,
    input  logic [AMOUNT_SIZE-1:0]     req_amount,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [2:0]                 rsp_status,
    output logic [CREDIT_VAL_SIZE-1:0] rsp_credit
);

    typedef enum logic [2:0] {IDLE, RD_SRC, CHK_SRC, RD_DST, CHK_DST, WR, RESP} state_t;

    localparam logic [1:0] OP_LOOKUP   = 2'd0;
    localparam logic [1:0] OP_DEPOSIT  = 2'd1;
    localparam logic [1:0] OP_WITHDRAW = 2'd2;
    localparam logic [1:0] OP_TRANSFER = 2'd3;

    localparam logic [2:0] ST_OK           = 3'd0;
    localparam logic [2:0] ST_BAD_CARD     = 3'd1;
    localparam logic [2:0] ST_BAD_PASS     = 3'd2;
    localparam logic [2:0] ST_BAD_DEST     = 3'd3;
    localparam logic [2:0] ST_OVER_LIMIT   = 3'd4;
    localparam logic [2:0] ST_INSUFFICIENT = 3'd5;
    localparam logic [2:0] ST_OVERFLOW     = 3'd6;

    // Sum one bit wider than a credit; the top bit flags overflow.
    function automatic logic [CREDIT_VAL_SIZE:0] add_credit(
        input logic [CREDIT_VAL_SIZE-1:0] a,
        input logic [CREDIT_VAL_SIZE-1:0] b
    );
        return {1'b0, a} + {1'b0, b};
    endfunction

    state_t state, next_state;

    logic [DEPTH-1:0]           card_valid;
    logic [PASSWORD_SIZE-1:0]   pass_mem   [DEPTH];
    logic [UP_LIMIT_SIZE-1:0]   limit_mem  [DEPTH];
    logic [CREDIT_VAL_SIZE-1:0] credit_mem [DEPTH];

    logic [1:0]                 op_r;
    logic [PINCARD_SIZE-1:0]    card_r, dest_r;
    logic [PASSWORD_SIZE-1:0]   pass_r;
    logic [AMOUNT_SIZE-1:0]     amount_r;

    logic                       src_valid, dst_valid;
    logic [PASSWORD_SIZE-1:0]   src_pass;
    logic [UP_LIMIT_SIZE-1:0]   src_limit;
    logic [CREDIT_VAL_SIZE-1:0] src_credit, dst_credit;
    logic [CREDIT_VAL_SIZE-1:0] new_src, new_dst;

    logic                       req_fire, init_write;
    logic                       load_rsp, load_new;
    logic [2:0]                 rsp_status_d;
    logic [CREDIT_VAL_SIZE-1:0] rsp_credit_d, new_src_d, new_dst_d;
    logic [CREDIT_VAL_SIZE-1:0] amt_c;
    logic [CREDIT_VAL_SIZE:0]   dep_sum, dst_sum;

    assign req_ready  = (state == IDLE) && !init_en;
    assign req_fire   = req_valid && req_ready;
    assign init_write = (state == IDLE) && init_en;

    assign amt_c   = {{(CREDIT_VAL_SIZE-AMOUNT_SIZE){1'b0}}, amount_r};
    assign dep_sum = add_credit(src_credit, amt_c);
    assign dst_sum = add_credit(dst_credit, amt_c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rsp_valid  <= 1'b0;
            rsp_status <= '0;
            rsp_credit <= '0;
            card_valid <= '0;
        end else begin
            state <= next_state;
            if (load_rsp) begin
                rsp_valid  <= 1'b1;
                rsp_status <= rsp_status_d;
                rsp_credit <= rsp_credit_d;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            if (init_write)
                card_valid[init_card] <= init_valid;
        end
    end

    // Record storage and request datapath carry no reset; the FSM gates every write.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            op_r     <= req_op;
            card_r   <= req_card;
            dest_r   <= req_dest;
            pass_r   <= req_pass;
            amount_r <= req_amount;
        end
        if (state == RD_SRC) begin
            src_valid  <= card_valid[card_r];
            src_pass   <= pass_mem[card_r];
            src_limit  <= limit_mem[card_r];
            src_credit <= credit_mem[card_r];
        end
        if (state == RD_DST) begin
            dst_valid  <= card_valid[dest_r];
            dst_credit <= credit_mem[dest_r];
        end
        if (load_new) begin
            new_src <= new_src_d;
            new_dst <= new_dst_d;
        end
        if (init_write) begin
            pass_mem[init_card]   <= init_pass;
            limit_mem[init_card]  <= init_limit;
            credit_mem[init_card] <= init_credit;
        end
        if (state == WR) begin
            credit_mem[card_r] <= new_src;
            if (op_r == OP_TRANSFER)
                credit_mem[dest_r] <= new_dst;
        end
    end

    always_comb begin
        next_state   = state;
        load_rsp     = 1'b0;
        load_new     = 1'b0;
        rsp_status_d = ST_OK;
        rsp_credit_d = src_credit;
        new_src_d    = src_credit - amt_c;
        new_dst_d    = dst_sum[CREDIT_VAL_SIZE-1:0];
        case (state)
            IDLE: begin
                if (req_fire)
                    next_state = RD_SRC;
            end
            RD_SRC: next_state = CHK_SRC;
            CHK_SRC: begin
                next_state = RESP;
                load_rsp   = 1'b1;
                if (!src_valid) begin
                    rsp_status_d = ST_BAD_CARD;
                    rsp_credit_d = '0;
                end else if (pass_r != src_pass) begin
                    rsp_status_d = ST_BAD_PASS;
                end else if (op_r == OP_LOOKUP) begin
                    rsp_status_d = ST_OK;
                end else if (op_r == OP_DEPOSIT) begin
                    if (dep_sum[CREDIT_VAL_SIZE]) begin
                        rsp_status_d = ST_OVERFLOW;
                    end else begin
                        new_src_d  = dep_sum[CREDIT_VAL_SIZE-1:0];
                        load_new   = 1'b1;
                        load_rsp   = 1'b0;
                        next_state = WR;
                    end
                end else if (amount_r > src_limit) begin
                    rsp_status_d = ST_OVER_LIMIT;
                end else if (amt_c > src_credit) begin
                    rsp_status_d = ST_INSUFFICIENT;
                end else if (op_r == OP_WITHDRAW) begin
                    load_new   = 1'b1;
                    load_rsp   = 1'b0;
                    next_state = WR;
                end else begin
                    load_rsp   = 1'b0;
                    next_state = RD_DST;
                end
            end
            RD_DST: next_state = CHK_DST;
            CHK_DST: begin
                next_state = RESP;
                load_rsp   = 1'b1;
                if (dest_r == card_r || !dst_valid) begin
                    rsp_status_d = ST_BAD_DEST;
                end else if (dst_sum[CREDIT_VAL_SIZE]) begin
                    rsp_status_d = ST_OVERFLOW;
                end else begin
                    load_new   = 1'b1;
                    load_rsp   = 1'b0;
                    next_state = WR;
                end
            end
            WR: begin
                load_rsp     = 1'b1;
                rsp_credit_d = new_src;
                next_state   = RESP;
            end
            RESP: begin
                if (rsp_ready)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_atm_account_store.sv
// Randomized + directed bench for atm_account_store against a behavioural account model.
module tb_atm_account_store;

    localparam longint MAXC = (64'd1 << 25) - 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_en = 1'b0;
    logic [5:0]  init_card = '0;
    logic        init_valid = 1'b0;
    logic [15:0] init_pass = '0;
    logic [14:0] init_limit = '0;
    logic [24:0] init_credit = '0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = '0;
    logic [5:0]  req_card = '0;
    logic [5:0]  req_dest = '0;
    logic [15:0] req_pass = '0;
    logic [14:0] req_amount = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [2:0]  rsp_status;
    logic [24:0] rsp_credit;

    always #5 clk = ~clk;

    atm_account_store dut (
        .clk(clk), .rst_n(rst_n),
        .init_en(init_en), .init_card(init_card), .init_valid(init_valid),
        .init_pass(init_pass), .init_limit(init_limit), .init_credit(init_credit),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_card(req_card), .req_dest(req_dest), .req_pass(req_pass),
        .req_amount(req_amount),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_status(rsp_status), .rsp_credit(rsp_credit)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural account model
    bit     mv [64];
    int     mp [64];
    int     ml [64];
    longint mc [64];

    bit     busy = 0, pend = 0, holding = 0;
    int     ncyc = 0, acc_cyc = 0;
    int     e_st = 0, e_lat = 0;
    longint e_cr = 0;
    bit     w_src, w_dst;
    int     w_card, w_dest;
    longint w_sv, w_dv;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic predict(input int op, input int card, input int dest, input int pass, input longint amt);
        w_src = 0; w_dst = 0; w_card = card; w_dest = dest;
        e_st = 0; e_cr = mc[card]; e_lat = 3;
        if (!mv[card]) begin
            e_st = 1; e_cr = 0;
        end else if (pass != mp[card]) begin
            e_st = 2;
        end else if (op == 0) begin
            e_st = 0;
        end else if (op == 1) begin
            if (mc[card] + amt > MAXC) e_st = 6;
            else begin e_cr = mc[card] + amt; e_lat = 4; w_src = 1; w_sv = e_cr; end
        end else if (amt > ml[card]) begin
            e_st = 4;
        end else if (amt > mc[card]) begin
            e_st = 5;
        end else if (op == 2) begin
            e_cr = mc[card] - amt; e_lat = 4; w_src = 1; w_sv = e_cr;
        end else begin
            e_lat = 5;
            if (dest == card || !mv[dest]) e_st = 3;
            else if (mc[dest] + amt > MAXC) e_st = 6;
            else begin
                e_lat = 6; e_cr = mc[card] - amt;
                w_src = 1; w_sv = e_cr; w_dst = 1; w_dv = mc[dest] + amt;
            end
        end
    endtask

    // Compare process: every negedge, outputs against the model
    always @(negedge clk) begin
        ncyc++;
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) mv[i] = 0;
            busy = 0; pend = 0; holding = 0;
            chk("reset_rsp_valid", rsp_valid, 0);
            chk("reset_rsp_status", rsp_status, 0);
            chk("reset_rsp_credit", rsp_credit, 0);
        end else begin
            chk("req_ready", req_ready, (!busy && !init_en));
            if (init_en && !busy) begin
                mv[init_card] = init_valid;
                mp[init_card] = int'(init_pass);
                ml[init_card] = int'(init_limit);
                mc[init_card] = longint'(init_credit);
            end
            if (req_valid && req_ready) begin
                predict(int'(req_op), int'(req_card), int'(req_dest), int'(req_pass), longint'(req_amount));
                busy = 1; pend = 1; acc_cyc = ncyc;
            end
            if (rsp_valid) begin
                if (!holding) begin
                    if (!pend) begin
                        chk("rsp_unexpected", rsp_valid, 0);
                    end else begin
                        chk("rsp_status", rsp_status, e_st);
                        chk("rsp_credit", rsp_credit, e_cr);
                        chk("rsp_latency", ncyc - acc_cyc, e_lat);
                        if (w_src) mc[w_card] = w_sv;
                        if (w_dst) mc[w_dest] = w_dv;
                        pend = 0; holding = 1;
                    end
                end else begin
                    chk("rsp_hold_status", rsp_status, e_st);
                    chk("rsp_hold_credit", rsp_credit, e_cr);
                end
                if (rsp_ready) begin holding = 0; busy = 0; end
            end else if (holding) begin
                chk("rsp_valid_held", rsp_valid, 1);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_init(input int card, input bit v, input int pass, input int limit, input longint credit);
        init_en = 1; init_card = 6'(card); init_valid = v;
        init_pass = 16'(pass); init_limit = 15'(limit); init_credit = 25'(credit);
        step();
        init_en = 0;
    endtask

    task automatic send_req(input int op, input int card, input int dest, input int pass, input int amt);
        int k;
        k = 0;
        while (!req_ready && k < 50) begin step(); k++; end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL req_ready_timeout: got 0 expected 1");
        end
        req_valid = 1; req_op = 2'(op); req_card = 6'(card); req_dest = 6'(dest);
        req_pass = 16'(pass); req_amount = 15'(amt);
        step();
        req_valid = 0;
    endtask

    task automatic wait_rsp(output logic [2:0] st, output logic [24:0] cr);
        int k;
        k = 0;
        while (!rsp_valid && k < 20) begin step(); k++; end
        if (!rsp_valid) begin
            checks++; errors++;
            $display("FAIL rsp_timeout: got 0 expected 1");
        end
        st = rsp_status; cr = rsp_credit;
    endtask

    task automatic do_req(input int op, input int card, input int dest, input int pass, input int amt,
                          input int hold, output logic [2:0] st, output logic [24:0] cr);
        rsp_ready = (hold == 0);
        send_req(op, card, dest, pass, amt);
        wait_rsp(st, cr);
        if (hold > 0) begin
            repeat (hold) step();
            rsp_ready = 1;
        end
        step();
        rsp_ready = 0;
    endtask

    logic [2:0]  st;
    logic [24:0] cr;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step();
        rst_n = 1;
        step();

        // Directed scenarios with hand-computed results
        do_init(5, 1, 'h1234, 500, 1000);
        do_req(0, 5, 0, 'h1234, 0, 0, st, cr);
        chk("lookup5_st", st, 0); chk("lookup5_cr", cr, 1000);
        do_req(2, 5, 0, 'h1234, 500, 1, st, cr);
        chk("wd500_st", st, 0); chk("wd500_cr", cr, 500);
        do_req(2, 5, 0, 'h1234, 501, 0, st, cr);
        chk("wd501_st", st, 4); chk("wd501_cr", cr, 500);
        do_req(2, 5, 0, 'h1234, 500, 2, st, cr);
        chk("wd_all_st", st, 0); chk("wd_all_cr", cr, 0);
        do_req(0, 5, 0, 'h1235, 0, 0, st, cr);
        chk("badpass_st", st, 2);
        do_req(0, 9, 0, 0, 0, 0, st, cr);
        chk("badcard_st", st, 1); chk("badcard_cr", cr, 0);

        do_init(6, 1, 'h6666, 100, MAXC);
        do_req(1, 6, 0, 'h6666, 1, 0, st, cr);
        chk("dep_ovf_st", st, 6); chk("dep_ovf_cr", cr, MAXC);
        do_req(1, 6, 0, 'h6666, 0, 0, st, cr);
        chk("dep_zero_st", st, 0); chk("dep_zero_cr", cr, MAXC);

        do_init(8, 1, 'h0008, 1000, 100);
        do_req(2, 8, 0, 'h0008, 101, 0, st, cr);
        chk("insuff_st", st, 5); chk("insuff_cr", cr, 100);

        do_init(5, 1, 'h1234, 500, 1000);
        do_init(7, 1, 'h7777, 100, 50);
        do_req(3, 5, 7, 'h1234, 200, 0, st, cr);
        chk("xfer_st", st, 0); chk("xfer_cr", cr, 800);
        do_req(0, 7, 0, 'h7777, 0, 0, st, cr);
        chk("xfer_dst_cr", cr, 250);
        do_req(3, 5, 5, 'h1234, 10, 0, st, cr);
        chk("xfer_self_st", st, 3); chk("xfer_self_cr", cr, 800);
        do_req(3, 5, 9, 'h1234, 10, 0, st, cr);
        chk("xfer_inval_st", st, 3);
        do_req(3, 5, 6, 'h1234, 1, 0, st, cr);
        chk("xfer_ovf_st", st, 6); chk("xfer_ovf_cr", cr, 800);

        // Response back-pressure; init attempts while busy must be ignored
        rsp_ready = 0;
        send_req(0, 5, 0, 'h1234, 0);
        wait_rsp(st, cr);
        init_en = 1; init_card = 6'd5; init_valid = 1; init_pass = 16'h1234;
        init_limit = 15'd500; init_credit = 25'd5;
        repeat (10) step();
        init_en = 0;
        rsp_ready = 1;
        step();
        rsp_ready = 0;
        chk("hold_st", st, 0); chk("hold_cr", cr, 800);
        do_req(0, 5, 0, 'h1234, 0, 0, st, cr);
        chk("after_hold_cr", cr, 800);

        // Reset asserted while the deposit sits in its write cycle
        rsp_ready = 0;
        send_req(1, 5, 0, 'h1234, 7);
        step(); step();
        rst_n = 0;
        step(); step();
        rst_n = 1;
        step();
        do_req(0, 5, 0, 'h1234, 0, 0, st, cr);
        chk("post_reset_st", st, 1); chk("post_reset_cr", cr, 0);

        // Randomized phase
        for (int c = 0; c < 8; c++)
            do_init(c, $urandom_range(0, 7) != 0, int'($urandom_range(0, 65535)),
                    int'($urandom_range(0, 32767)),
                    ($urandom_range(0, 1) == 1) ? MAXC - longint'($urandom_range(0, 40000))
                                                : longint'($urandom_range(0, 50000)));
        for (int it = 0; it < 200; it++) begin
            int op, card, dest, pass, amt, tgt, sel;
            longint head;
            if (it % 25 == 24)
                do_init($urandom_range(0, 8), $urandom_range(0, 5) != 0, int'($urandom_range(0, 65535)),
                        int'($urandom_range(0, 32767)), MAXC - longint'($urandom_range(0, 32768)));
            op   = $urandom_range(0, 3);
            card = $urandom_range(0, 8);
            dest = ($urandom_range(0, 4) == 0) ? card : int'($urandom_range(0, 8));
            pass = ($urandom_range(0, 9) == 0) ? (mp[card] ^ 1) : mp[card];
            tgt  = (op == 3) ? dest : card;
            sel  = $urandom_range(0, 5);
            amt  = int'($urandom_range(0, 32767));
            case (sel)
                1: amt = ml[card];
                2: amt = (ml[card] < 32767) ? ml[card] + 1 : ml[card];
                3: if (mc[card] <= 32767) amt = int'(mc[card]);
                4: begin
                    head = MAXC - mc[tgt] + longint'($urandom_range(0, 1));
                    if (head <= 32767) amt = int'(head);
                end
                5: amt = 0;
                default: ;
            endcase
            do_req(op, card, dest, pass, amt, $urandom_range(0, 3), st, cr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
